// File: rtl/gumnut_port_responder_if.sv
// Gumnut I/O port bus between the CPU (initiator) and a port responder.
//   port_cyc_i / port_stb_i : bus cycle valid / strobe (request = cyc & stb)
//   port_we_i               : 1 = out (write), 0 = inp (read)
//   port_adr_i / port_dat_i : port address / write data
//   port_dat_o              : read data, non-zero only while port_ack_o = 1
//   port_ack_o              : one-cycle acknowledge
`timescale 1ns/1ps
interface gumnut_port_responder_if;
  logic       port_cyc_i;
  logic       port_stb_i;
  logic       port_we_i;
  logic [7:0] port_adr_i;
  logic [7:0] port_dat_i;
  logic [7:0] port_dat_o;
  logic       port_ack_o;

  modport master (
    output port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
    input  port_dat_o, port_ack_o
  );

  modport slave (
    input  port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
    output port_dat_o, port_ack_o
  );
endinterface

// File: rtl/gumnut_port_responder.sv
// Responder end of the Gumnut I/O port bus: an 8-register window holding an
// output port, a synchronised input port and (optionally) an interval timer
// that drives the CPU interrupt request.
// Ports:
//   clk_i, rst_ni   : clock (posedge), asynchronous active-low reset
//   bus             : gumnut_port_responder_if.slave (cyc/stb/we/adr/dat, ack/dat_o)
//   in_port_i       : asynchronous external input (2-flop synchronised)
//   out_port_o      : OUT register
//   int_ack_i       : CPU interrupt acknowledge (clears EXP)
//   int_req_o       : registered EXP & IEN
// Build option: define GUMNUT_PORT_TIMER_EN to include the timer, CTRL, STATUS
// and interrupt logic; otherwise registers 2..5 read 0 and int_req_o is 0.
`timescale 1ns/1ps
module gumnut_port_responder #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  OUT_RESET   = 8'h00
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  gumnut_port_responder_if.slave        bus,
  input  logic [7:0]                    in_port_i,
  output logic [7:0]                    out_port_o,
  input  logic                          int_ack_i,
  output logic                          int_req_o
);

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_IN     = 3'd1;
  localparam logic [2:0] REG_RELOAD = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_c;
  logic             hit_c;
  logic             wr_c;
  logic [2:0]       reg_sel_c;
  logic [DW-1:0]    rd_mux_c;

  logic             ack_q;
  logic [DW-1:0]    rdat_q;
  logic [DW-1:0]    out_q;
  logic [DW-1:0]    sync_q1, sync_q2;

  // Request decode; the window is matched on the upper five address bits
  assign req_c     = bus.port_cyc_i & bus.port_stb_i;
  assign hit_c     = (bus.port_adr_i[7:3] == BASE_ADDR[7:3]);
  assign reg_sel_c = bus.port_adr_i[2:0];
  // Writes commit on the edge that ends the ACK cycle
  assign wr_c      = (state_q == ST_ACK) & bus.port_we_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; WAIT leaves when the decremented count reaches zero so
  // that ack lands WAIT_STATES+1 cycles after the request is sampled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c && hit_c) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered ack and read data, both launched on entry to ACK
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= (state_d == ST_ACK);
      rdat_q <= (state_d == ST_ACK) ? rd_mux_c : '0;
    end
  end

  // Input synchroniser and OUT register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      out_q   <= OUT_RESET;
    end else begin
      sync_q1 <= in_port_i;
      sync_q2 <= sync_q1;
      if (wr_c && (reg_sel_c == REG_OUT)) begin
        out_q <= bus.port_dat_i;
      end
    end
  end

`ifdef GUMNUT_PORT_TIMER_EN
  logic [DW-1:0] reload_q;
  logic [DW-1:0] count_q;
  logic          ten_q;
  logic          ien_q;
  logic          exp_q;
  logic          int_req_q;
  logic          ten_start_c;
  logic          expire_c;
  logic          exp_clr_c;

  assign ten_start_c = wr_c & (reg_sel_c == REG_CTRL) & bus.port_dat_i[0] & ~ten_q;
  assign expire_c    = ten_q & (count_q == '0);
  assign exp_clr_c   = int_ack_i | (wr_c & (reg_sel_c == REG_STATUS) & bus.port_dat_i[0]);

  // Interval timer; expiry wins over any simultaneous EXP clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reload_q  <= '0;
      count_q   <= '0;
      ten_q     <= 1'b0;
      ien_q     <= 1'b0;
      exp_q     <= 1'b0;
      int_req_q <= 1'b0;
    end else begin
      if (wr_c && (reg_sel_c == REG_RELOAD)) begin
        reload_q <= bus.port_dat_i;
      end
      if (wr_c && (reg_sel_c == REG_CTRL)) begin
        ten_q <= bus.port_dat_i[0];
        ien_q <= bus.port_dat_i[1];
      end
      if (ten_start_c) begin
        count_q <= reload_q;
      end else if (ten_q) begin
        count_q <= expire_c ? reload_q : count_q - DW'(1);
      end
      if (expire_c) begin
        exp_q <= 1'b1;
      end else if (exp_clr_c) begin
        exp_q <= 1'b0;
      end
      int_req_q <= exp_q & ien_q;
    end
  end

  assign int_req_o = int_req_q;
`else
  logic unused_int_ack;

  assign unused_int_ack = int_ack_i;
  assign int_req_o      = 1'b0;
`endif

  // Read mux; unmapped or absent registers read zero
  always_comb begin
    rd_mux_c = '0;
    case (reg_sel_c)
      REG_OUT:    rd_mux_c = out_q;
      REG_IN:     rd_mux_c = sync_q2;
`ifdef GUMNUT_PORT_TIMER_EN
      REG_RELOAD: rd_mux_c = reload_q;
      REG_COUNT:  rd_mux_c = count_q;
      REG_CTRL:   rd_mux_c = {6'b0, ien_q, ten_q};
      REG_STATUS: rd_mux_c = {7'b0, exp_q};
`endif
      default:    rd_mux_c = '0;
    endcase
  end

  assign bus.port_ack_o = ack_q;
  assign bus.port_dat_o = rdat_q;
  assign out_port_o     = out_q;

endmodule

// File: tb/tb_gumnut_port_responder.sv
// Directed + randomized bench for gumnut_port_responder. Two instances share
// one set of bus drive variables: u_dut1 (WAIT_STATES=1) and u_dut3
// (WAIT_STATES=3, OUT_RESET=8'h5C); 'sel' chooses which one sees cyc.
`timescale 1ns/1ps
module tb_gumnut_port_responder;

  localparam logic [7:0] OUT_RST1 = 8'h00;
  localparam logic [7:0] OUT_RST3 = 8'h5C;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  gumnut_port_responder_if bus1();
  gumnut_port_responder_if bus3();

  logic       sel;
  logic       b_cyc, b_stb, b_we;
  logic [7:0] b_adr, b_dat;
  logic [7:0] in_port;
  logic       int_ack;
  logic [7:0] out1, out3;
  logic       irq1, irq3;
  logic       ack_sel;
  logic [7:0] dat_sel;

  assign bus1.port_cyc_i = b_cyc & ~sel;
  assign bus1.port_stb_i = b_stb;
  assign bus1.port_we_i  = b_we;
  assign bus1.port_adr_i = b_adr;
  assign bus1.port_dat_i = b_dat;
  assign bus3.port_cyc_i = b_cyc & sel;
  assign bus3.port_stb_i = b_stb;
  assign bus3.port_we_i  = b_we;
  assign bus3.port_adr_i = b_adr;
  assign bus3.port_dat_i = b_dat;
  assign ack_sel = sel ? bus3.port_ack_o : bus1.port_ack_o;
  assign dat_sel = sel ? bus3.port_dat_o : bus1.port_dat_o;

  gumnut_port_responder #(.BASE_ADDR(8'h00), .WAIT_STATES(1), .OUT_RESET(OUT_RST1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus1), .in_port_i(in_port),
    .out_port_o(out1), .int_ack_i(int_ack), .int_req_o(irq1)
  );

  gumnut_port_responder #(.BASE_ADDR(8'h00), .WAIT_STATES(3), .OUT_RESET(OUT_RST3)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus3), .in_port_i(in_port),
    .out_port_o(out3), .int_ack_i(int_ack), .int_req_o(irq3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_out [2];
  logic [7:0] m_rel [2];
  logic [7:0] m_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] m_read(input logic s, input logic [2:0] a);
    case (a)
      3'd0:    return m_out[s];
      3'd1:    return m_in;
`ifdef GUMNUT_PORT_TIMER_EN
      3'd2:    return m_rel[s];
`endif
      default: return 8'h00;
    endcase
  endfunction

  function automatic int exp_lat(input logic s);
    return s ? 4 : 2;
  endfunction

  // One bus transfer; called and returning at posedge+1
  task automatic xfer(input logic s, input logic we, input logic [7:0] adr, input logic [7:0] wd,
                      output logic [7:0] rd, output int lat);
    sel = s; b_we = we; b_adr = adr; b_dat = wd; b_cyc = 1'b1; b_stb = 1'b1;
    lat = 0;
    rd  = 8'h00;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (ack_sel !== 1'b1 && lat < 40);
    if (ack_sel === 1'b1) rd = dat_sel;
    @(posedge clk_i); #1;
    if (lat < 40) chk("ack_one_cycle", ack_sel, 1'b0);
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
  endtask

  task automatic wr(input logic s, input logic [7:0] adr, input logic [7:0] d, input string tag);
    logic [7:0] rd;
    int lat;
    xfer(s, 1'b1, adr, d, rd, lat);
    chk({tag, "_lat"}, lat, exp_lat(s));
  endtask

  task automatic rd_chk(input logic s, input logic [7:0] adr, input logic [7:0] expv, input string tag);
    logic [7:0] rd;
    int lat;
    xfer(s, 1'b0, adr, 8'h00, rd, lat);
    chk({tag, "_lat"}, lat, exp_lat(s));
    chk({tag, "_dat"}, rd, expv);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s, we;
    logic [2:0] a;
    logic [7:0] d;
    int         acks;
    sel = 1'b0; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = 8'h00; b_dat = 8'h00;
    in_port = 8'h00; int_ack = 1'b0;
    m_out[0] = OUT_RST1; m_out[1] = OUT_RST3; m_rel[0] = 8'h00; m_rel[1] = 8'h00; m_in = 8'h00;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack1", bus1.port_ack_o, 1'b0);
    chk("rst_dat1", bus1.port_dat_o, 8'h00);
    chk("rst_out1", out1, OUT_RST1);
    chk("rst_out3", out3, OUT_RST3);
    chk("rst_irq1", irq1, 1'b0);
    chk("rst_irq3", irq3, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Write / readback with one wait state
    wr(1'b0, 8'h00, 8'hA5, "wr_a5");
    chk("out_after_wr", out1, 8'hA5);
    m_out[0] = 8'hA5;
    rd_chk(1'b0, 8'h00, 8'hA5, "rd_a5");
    chk("dat_idle", bus1.port_dat_o, 8'h00);

    // Input synchroniser
    in_port = 8'h3C; m_in = 8'h3C;
    repeat (3) @(posedge clk_i);
    #1;
    rd_chk(1'b0, 8'h01, 8'h3C, "rd_in");

    // Address miss: no ack for 20 cycles, nothing written
    sel = 1'b0; b_we = 1'b1; b_adr = 8'h40; b_dat = 8'hFF; b_cyc = 1'b1; b_stb = 1'b1;
    acks = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (bus1.port_ack_o === 1'b1) acks++;
    end
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    chk("miss_acks", acks, 0);
    chk("miss_out", out1, 8'hA5);
    rd_chk(1'b0, 8'h00, 8'hA5, "miss_rd");

    // Three wait states, then abort during WAIT
    wr(1'b1, 8'h00, 8'h11, "wr3");
    m_out[1] = 8'h11;
    chk("out3_after_wr", out3, 8'h11);
    sel = 1'b1; b_we = 1'b1; b_adr = 8'h00; b_dat = 8'hFF; b_cyc = 1'b1; b_stb = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    b_stb = 1'b0;
    acks = 0;
    repeat (10) begin
      @(posedge clk_i); #1;
      if (bus3.port_ack_o === 1'b1) acks++;
    end
    b_cyc = 1'b0; b_we = 1'b0;
    chk("abort_acks", acks, 0);
    chk("abort_out", out3, 8'h11);
    rd_chk(1'b1, 8'h00, 8'h11, "abort_rd");

    // Randomized register traffic on both instances
    for (int it = 0; it < 24; it++) begin
      s = 1'($urandom_range(0, 1));
      in_port = 8'($urandom); m_in = in_port;
      repeat (3) @(posedge clk_i);
      #1;
      a  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
`ifdef GUMNUT_PORT_TIMER_EN
      if (a >= 3'd3 && a <= 3'd5) a = 3'd6;
`endif
      if (we) begin
        wr(s, {5'b0, a}, d, "rnd_wr");
        if (a == 3'd0) m_out[s] = d;
`ifdef GUMNUT_PORT_TIMER_EN
        if (a == 3'd2) m_rel[s] = d;
`endif
        chk("rnd_out1", out1, m_out[0]);
        chk("rnd_out3", out3, m_out[1]);
      end else begin
        rd_chk(s, {5'b0, a}, m_read(s, a), "rnd_rd");
      end
    end

`ifdef GUMNUT_PORT_TIMER_EN
    begin
      logic exp_m, req_m;
      int   r;
      // RELOAD=4: expiry every 5 cycles, ack pulse and coincident ack
      wr(1'b0, 8'h02, 8'h04, "tmr_rel");
      wr(1'b0, 8'h04, 8'h03, "tmr_ctrl");
      r = 4; exp_m = 1'b0; req_m = 1'b0;
      for (int n = 1; n <= 30; n++) begin
        int_ack = (n == 8 || n == 15);
        @(posedge clk_i); #1;
        req_m = exp_m;
        if (n % (r + 1) == 0) exp_m = 1'b1;
        else if (int_ack) exp_m = 1'b0;
        chk("irq_r4", irq1, req_m);
      end
      int_ack = 1'b0;
      wr(1'b0, 8'h04, 8'h00, "tmr_off");
      int_ack = 1'b1;
      @(posedge clk_i); #1;
      int_ack = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("irq_off", irq1, 1'b0);
      rd_chk(1'b0, 8'h05, 8'h00, "status_clr");

      // Random reload with random acknowledges
      r = $urandom_range(0, 6);
      wr(1'b0, 8'h02, 8'(r), "tmr_rel_rnd");
      wr(1'b0, 8'h04, 8'hFF, "tmr_ctrl_ff");
      exp_m = 1'b0; req_m = 1'b0;
      for (int n = 1; n <= 40; n++) begin
        int_ack = ($urandom_range(0, 3) == 0);
        @(posedge clk_i); #1;
        req_m = exp_m;
        if (n % (r + 1) == 0) exp_m = 1'b1;
        else if (int_ack) exp_m = 1'b0;
        chk("irq_rnd", irq1, req_m);
      end
      int_ack = 1'b0;
      rd_chk(1'b0, 8'h04, 8'h03, "ctrl_rd");

      // STATUS write-1-to-clear
      wr(1'b0, 8'h02, 8'h00, "st_rel0");
      wr(1'b0, 8'h04, 8'h01, "st_ten");
      wr(1'b0, 8'h04, 8'h00, "st_toff");
      rd_chk(1'b0, 8'h05, 8'h01, "st_set");
      wr(1'b0, 8'h05, 8'hFE, "st_w0");
      rd_chk(1'b0, 8'h05, 8'h01, "st_w0_rd");
      wr(1'b0, 8'h05, 8'h01, "st_w1");
      rd_chk(1'b0, 8'h05, 8'h00, "st_w1_rd");
      chk("st_irq", irq1, 1'b0);
    end
`else
    // Timer absent: CTRL write acked and ignored, no interrupts
    wr(1'b0, 8'h04, 8'h03, "noten_ctrl");
    rd_chk(1'b0, 8'h04, 8'h00, "noten_rd");
    acks = 0;
    repeat (100) begin
      int_ack = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      if (irq1 !== 1'b0) acks++;
    end
    int_ack = 1'b0;
    chk("noten_irq", acks, 0);
`endif

    // Reset during WAIT: write lost, no ack, outputs back to reset values
    sel = 1'b1; b_we = 1'b1; b_adr = 8'h00; b_dat = 8'h5A; b_cyc = 1'b1; b_stb = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("rstw_ack", bus3.port_ack_o, 1'b0);
    chk("rstw_out3", out3, OUT_RST3);
    chk("rstw_out1", out1, OUT_RST1);
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_out[0] = OUT_RST1; m_out[1] = OUT_RST3;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rstw_out3_after", out3, OUT_RST3);
    rd_chk(1'b1, 8'h00, OUT_RST3, "rstw_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
